gbc_video_memory_arbiter: RTL and testbench
===========================================

GBC_VIDEO_MEMORY_ARBITER -- requirements
Module: gbc_video_memory_arbiter

Interface
REQ-001 SHALL have parameter VRAM_BANKS, default 2, number of 8 KiB VRAM banks (1 or 2); VramAddress width = 13 + (VRAM_BANKS==2).
REQ-002 SHALL have parameter OAM_BYTES, default 160, OAM array depth (<=256).
REQ-003 SHALL have port Clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port nReset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ClkEn, input, 1, advances all state when high.
REQ-006 SHALL have port Mode, input, 2, PPU mode 0-3.
REQ-007 SHALL have port VramBank, input, 1, CPU bank select (ignored when VRAM_BANKS==1).
REQ-008 SHALL have port CpuAccess, input, 1, CPU request strobe, one ClkEn cycle.
REQ-009 SHALL have port CpuWrite, input, 1, 1=write, 0=read.
REQ-010 SHALL have port CpuAddress, input, 16, CPU byte address.
REQ-011 SHALL have port CpuWData, input, 8, CPU write data.
REQ-012 SHALL have port CpuRData, output, 8, CPU read data, valid with CpuDataReady.
REQ-013 SHALL have port CpuDataReady, output, 1, one-cycle pulse completing any CPU request.
REQ-014 SHALL have port PpuAccess, input, 1, PPU VRAM fetch strobe.
REQ-015 SHALL have port PpuAddress, input, 14, {bank, offset[12:0]}; PPU samples VramRData.
REQ-016 SHALL have port PpuOamAddress, input, 8, PPU OAM read index.
REQ-017 SHALL have port PpuOamRData, output, 8, registered OAM[PpuOamAddress], 1-cycle latency.
REQ-018 SHALL have port VramAccess/VramWrite/VramWData, output, 1/1/8, VRAM request.
REQ-019 SHALL have port VramAddress, output, 13-14, VRAM address.
REQ-020 SHALL have port VramRData, input, 8, synchronous VRAM data, valid 1 ClkEn cycle after VramAccess.
REQ-021 SHALL have port DmaStart/DmaSource, input, 1/8, FF46 write strobe and source page.
REQ-022 SHALL have port DmaActive, output, 1, OAM DMA in progress.
REQ-023 SHALL have port DmaAccess/DmaAddress, output, 1/16, DMA source read request.
REQ-024 SHALL have port DmaRData, input, 8, source data, valid 1 ClkEn cycle after DmaAccess.

Function
REQ-025 SHALL decode CPU: $8000-$9FFF VRAM, $FE00..$FE00+OAM_BYTES-1 OAM; any other address completes with CpuRData=$FF, no side effect.
REQ-026 SHALL give PPU sole VRAM ownership when Mode==3; else CPU owns VRAM and PpuAccess is ignored.
REQ-027 SHALL drive VramAddress={VramBank,CpuAddress[12:0]} for CPU, PpuAddress for PPU; combinational passthrough, VramWrite never asserted for PPU.
REQ-028 SHALL block CPU VRAM in Mode 3: reads return $FF, writes dropped, no VramAccess.
REQ-029 SHALL block CPU OAM when Mode[1]==1 or DmaActive: reads $FF, writes dropped.
REQ-030 SHALL complete every CPU request with CpuDataReady exactly one ClkEn cycle after CpuAccess, for all targets including blocked ones.
REQ-031 SHALL implement DMA FSM IDLE->REQ->WAIT->REQ...; IDLE on reset; DmaStart (any state) loads source, index=0, enters REQ.
REQ-032 SHALL in REQ assert DmaAccess with DmaAddress={DmaSource,index[7:0]}, go WAIT; WAIT writes OAM[index]=DmaRData, index++, returns to REQ, or IDLE after index OAM_BYTES-1.
REQ-033 SHALL assert DmaActive in REQ and WAIT; DMA writes OAM regardless of Mode; DMA write wins over simultaneous CPU write.
REQ-034 SHALL hold all state and outputs when ClkEn is low; strobes count only with ClkEn high.

Reset
REQ-035 SHALL on nReset low asynchronously: FSM IDLE, index 0, DmaActive/DmaAccess/CpuDataReady/VramAccess-registered=0, CpuRData=$FF, PpuOamRData=$FF; OAM contents not reset; a DMA in progress is abandoned.

Verification
REQ-036 Mode 0, CPU write $8123=$5A bank1, then read -> VramAddress $2123, CpuRData $5A next cycle.
REQ-037 Mode 3, CPU read $8000 and write $8001 -> CpuRData $FF, no VramWrite, PPU fetch $0040 drives VramAddress $0040.
REQ-038 Mode 2, CPU write $FE00=$11 then Mode 0 read -> prior value returned, $11 never stored.
REQ-039 DmaStart source $C1, source bytes i^$A5 -> after 320 ClkEn cycles OAM[i]=i^$A5 for i 0-159, DmaActive falls, CPU OAM reads $FF during.
REQ-040 DmaStart at index 80 with new source -> index restarts at 0, full 160 bytes from new page.
REQ-041 nReset low mid-DMA -> DmaActive 0 immediately, OAM bytes written before reset retained.

Source files
------------

// File: rtl/gbc_video_memory_arbiter_if.sv
// gbc_video_memory_arbiter_if: CPU, PPU, VRAM and OAM-DMA buses around the video memory arbiter
interface gbc_video_memory_arbiter_if #(parameter int VRAM_BANKS = 2);
  localparam int AW = 13 + ((VRAM_BANKS == 2) ? 1 : 0);
  logic [1:0] Mode;
  logic VramBank;
  logic CpuAccess;
  logic CpuWrite;
  logic [15:0] CpuAddress;
  logic [7:0] CpuWData;
  logic [7:0] CpuRData;
  logic CpuDataReady;
  logic PpuAccess;
  logic [13:0] PpuAddress;
  logic [7:0] PpuOamAddress;
  logic [7:0] PpuOamRData;
  logic VramAccess;
  logic VramWrite;
  logic [7:0] VramWData;
  logic [AW-1:0] VramAddress;
  logic [7:0] VramRData;
  logic DmaStart;
  logic [7:0] DmaSource;
  logic DmaActive;
  logic DmaAccess;
  logic [15:0] DmaAddress;
  logic [7:0] DmaRData;
  modport slave (
    input Mode, VramBank, CpuAccess, CpuWrite, CpuAddress, CpuWData,
          PpuAccess, PpuAddress, PpuOamAddress, VramRData, DmaStart, DmaSource, DmaRData,
    output CpuRData, CpuDataReady, PpuOamRData, VramAccess, VramWrite, VramWData, VramAddress,
           DmaActive, DmaAccess, DmaAddress
  );
  modport master (
    output Mode, VramBank, CpuAccess, CpuWrite, CpuAddress, CpuWData,
           PpuAccess, PpuAddress, PpuOamAddress, VramRData, DmaStart, DmaSource, DmaRData,
    input CpuRData, CpuDataReady, PpuOamRData, VramAccess, VramWrite, VramWData, VramAddress,
          DmaActive, DmaAccess, DmaAddress
  );
endinterface

// File: rtl/gbc_video_memory_arbiter.sv
// gbc_video_memory_arbiter: VRAM/OAM arbitration between CPU, PPU and OAM DMA with a fixed one-cycle CPU completion
module gbc_video_memory_arbiter #(
  parameter int VRAM_BANKS = 2,
  parameter int OAM_BYTES = 160
) (
  input logic Clk,
  input logic nReset,
  input logic ClkEn,
  gbc_video_memory_arbiter_if.slave bus
);
  localparam int AW = 13 + ((VRAM_BANKS == 2) ? 1 : 0);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} dma_state_t;
  dma_state_t state;
  logic [7:0] oam [OAM_BYTES];
  logic [7:0] dma_src, dma_idx, cpu_rdata_q, oam_rdata_q, cpu_oam_idx;
  logic cpu_ready_q, vram_pend_q, dma_active_q, dma_access_q;
  logic ppu_owns, vram_hit, oam_hit, cpu_vram_ok, cpu_oam_ok, cpu_oam_wr, dma_wr, dma_last;
  logic [AW-1:0] cpu_vaddr;
  assign ppu_owns = bus.Mode == 2'd3;
  assign vram_hit = bus.CpuAddress[15:13] == 3'b100;
  assign oam_hit = bus.CpuAddress[15:8] == 8'hFE && {1'b0, bus.CpuAddress[7:0]} < 9'(OAM_BYTES);
  assign cpu_vram_ok = bus.CpuAccess && vram_hit && !ppu_owns;
  assign cpu_oam_ok = bus.CpuAccess && oam_hit && !bus.Mode[1] && !dma_active_q;
  assign cpu_oam_idx = bus.CpuAddress[7:0];
  assign cpu_oam_wr = ClkEn && nReset && cpu_oam_ok && bus.CpuWrite;
  assign dma_wr = ClkEn && state == WAIT && !bus.DmaStart;
  assign dma_last = dma_idx == 8'(OAM_BYTES - 1);
  assign cpu_vaddr = AW'({bus.VramBank && VRAM_BANKS == 2, bus.CpuAddress[12:0]});
  assign bus.VramAccess = ppu_owns ? bus.PpuAccess : bus.CpuAccess && vram_hit;
  assign bus.VramWrite = cpu_vram_ok && bus.CpuWrite;
  assign bus.VramWData = bus.CpuWData;
  assign bus.VramAddress = ppu_owns ? AW'(bus.PpuAddress) : cpu_vaddr;
  // VRAM reads return straight from the synchronous RAM so they still complete one cycle later
  assign bus.CpuRData = vram_pend_q ? bus.VramRData : cpu_rdata_q;
  assign bus.CpuDataReady = cpu_ready_q;
  assign bus.PpuOamRData = oam_rdata_q;
  assign bus.DmaActive = dma_active_q;
  assign bus.DmaAccess = dma_access_q;
  assign bus.DmaAddress = {dma_src, dma_idx};
  always_ff @(posedge Clk) begin
    if (dma_wr) oam[dma_idx] <= bus.DmaRData;
    else if (cpu_oam_wr) oam[cpu_oam_idx] <= bus.CpuWData;
  end
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cpu_ready_q <= 1'b0;
      vram_pend_q <= 1'b0;
      cpu_rdata_q <= 8'hFF;
      oam_rdata_q <= 8'hFF;
    end else if (ClkEn) begin
      cpu_ready_q <= bus.CpuAccess;
      vram_pend_q <= cpu_vram_ok && !bus.CpuWrite;
      cpu_rdata_q <= cpu_oam_ok && !bus.CpuWrite ? oam[cpu_oam_idx] : 8'hFF;
      oam_rdata_q <= {1'b0, bus.PpuOamAddress} < 9'(OAM_BYTES) ? oam[bus.PpuOamAddress] : 8'hFF;
    end
  end
  // A new DmaStart always restarts from byte 0 and suppresses the pending OAM write
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
      dma_idx <= 8'd0;
      dma_src <= 8'd0;
      dma_active_q <= 1'b0;
      dma_access_q <= 1'b0;
    end else if (ClkEn) begin
      if (bus.DmaStart) begin
        state <= REQ;
        dma_src <= bus.DmaSource;
        dma_idx <= 8'd0;
        dma_active_q <= 1'b1;
        dma_access_q <= 1'b1;
      end else if (state == REQ) begin
        state <= WAIT;
        dma_access_q <= 1'b0;
      end else if (state == WAIT) begin
        state <= dma_last ? IDLE : REQ;
        dma_active_q <= !dma_last;
        dma_access_q <= !dma_last;
        dma_idx <= dma_last ? dma_idx : dma_idx + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_gbc_video_memory_arbiter.sv
// tb_gbc_video_memory_arbiter: directed and random stimulus against a cycle-counting reference model
module tb_gbc_video_memory_arbiter;
  logic Clk = 1'b0;
  logic nReset = 1'b0;
  logic ClkEn = 1'b0;
  gbc_video_memory_arbiter_if #(.VRAM_BANKS(2)) bus ();
  gbc_video_memory_arbiter #(.VRAM_BANKS(2), .OAM_BYTES(160)) dut (
    .Clk(Clk), .nReset(nReset), .ClkEn(ClkEn), .bus(bus)
  );
  always #5 Clk = ~Clk;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] dev_vram [16384];
  logic [7:0] vram_m [16384];
  logic [7:0] oam_m [160];
  bit oam_k [160];
  logic [7:0] vram_rd_dev = 8'h00;
  logic [7:0] dma_rd_dev = 8'h00;
  assign bus.VramRData = vram_rd_dev;
  assign bus.DmaRData = dma_rd_dev;
  bit m_ready, m_read, m_known, dma_on, p_known;
  logic [7:0] m_rdata, dma_src_m, p_oam;
  int dma_cyc;
  bit s_vacc, s_vwr, s_dacc;
  logic [13:0] s_vaddr;
  logic [7:0] s_vwd;
  logic [15:0] s_daddr;
  function automatic logic [7:0] src_mem(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ (a[15:8] == 8'hC1 ? 8'h00 : a[15:8]);
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    dma_on = 0;
    dma_cyc = 0;
    m_ready = 0;
    m_read = 0;
    m_known = 0;
    p_oam = 8'hFF;
    p_known = 1;
  endtask
  task automatic check_outputs();
    bit vh, eacc, ewr;
    vh = bus.CpuAddress >= 16'h8000 && bus.CpuAddress <= 16'h9FFF;
    eacc = bus.Mode == 2'd3 ? bus.PpuAccess : (bus.CpuAccess && vh);
    ewr = bus.Mode != 2'd3 && bus.CpuAccess && vh && bus.CpuWrite;
    chk("cpu_ready", 16'(bus.CpuDataReady), 16'(m_ready));
    if (m_ready && m_read && m_known) chk("cpu_rdata", 16'(bus.CpuRData), 16'(m_rdata));
    chk("dma_active", 16'(bus.DmaActive), 16'(dma_on));
    chk("dma_access", 16'(bus.DmaAccess), 16'(dma_on && dma_cyc % 2 == 0));
    if (dma_on && dma_cyc % 2 == 0) chk("dma_addr", bus.DmaAddress, {dma_src_m, 8'(dma_cyc / 2)});
    if (p_known) chk("ppu_oam", 16'(bus.PpuOamRData), 16'(p_oam));
    chk("vram_access", 16'(bus.VramAccess), 16'(eacc));
    chk("vram_write", 16'(bus.VramWrite), 16'(ewr));
    if (eacc) chk("vram_addr", 16'(bus.VramAddress), bus.Mode == 2'd3 ? 16'(bus.PpuAddress) : 16'({bus.VramBank, bus.CpuAddress[12:0]}));
    if (ewr) chk("vram_wdata", 16'(bus.VramWData), 16'(bus.CpuWData));
    s_vacc = bus.VramAccess;
    s_vwr = bus.VramWrite;
    s_vaddr = bus.VramAddress;
    s_vwd = bus.VramWData;
    s_dacc = bus.DmaAccess;
    s_daddr = bus.DmaAddress;
  endtask
  task automatic advance();
    logic [7:0] rd;
    logic [13:0] va;
    bit rk, vh, oh;
    int oi;
    if (!ClkEn) return;
    if (s_vacc) begin
      if (s_vwr) dev_vram[s_vaddr] = s_vwd;
      else vram_rd_dev = dev_vram[s_vaddr];
    end
    if (s_dacc) dma_rd_dev = src_mem(s_daddr);
    p_oam = oam_m[bus.PpuOamAddress];
    p_known = oam_k[bus.PpuOamAddress];
    vh = bus.CpuAddress >= 16'h8000 && bus.CpuAddress <= 16'h9FFF;
    oh = bus.CpuAddress >= 16'hFE00 && bus.CpuAddress < 16'hFE00 + 16'd160;
    oi = int'(bus.CpuAddress) - 'hFE00;
    rd = 8'hFF;
    rk = 1;
    if (bus.CpuAccess && vh && bus.Mode != 2'd3) begin
      va = {bus.VramBank, bus.CpuAddress[12:0]};
      if (bus.CpuWrite) vram_m[va] = bus.CpuWData;
      else rd = vram_m[va];
    end else if (bus.CpuAccess && oh && !bus.Mode[1] && !dma_on) begin
      if (bus.CpuWrite) begin
        oam_m[oi] = bus.CpuWData;
        oam_k[oi] = 1;
      end else begin
        rd = oam_m[oi];
        rk = oam_k[oi];
      end
    end
    m_ready = bus.CpuAccess;
    m_read = bus.CpuAccess && !bus.CpuWrite;
    m_rdata = rd;
    m_known = rk;
    if (bus.DmaStart) begin
      dma_on = 1;
      dma_src_m = bus.DmaSource;
      dma_cyc = 0;
    end else if (dma_on) begin
      if (dma_cyc % 2 == 1) begin
        oam_m[dma_cyc / 2] = src_mem({dma_src_m, 8'(dma_cyc / 2)});
        oam_k[dma_cyc / 2] = 1;
      end
      dma_cyc++;
      if (dma_cyc == 320) dma_on = 0;
    end
  endtask
  task automatic step();
    #1;
    check_outputs();
    @(posedge Clk);
    #1;
    advance();
    @(negedge Clk);
  endtask
  task automatic cpu_op(input bit w, input logic [15:0] a, input logic [7:0] d);
    bus.CpuAccess = 1;
    bus.CpuWrite = w;
    bus.CpuAddress = a;
    bus.CpuWData = d;
    step();
    bus.CpuAccess = 0;
    bus.CpuWrite = 0;
  endtask
  task automatic dma_kick(input logic [7:0] src);
    bus.DmaStart = 1;
    bus.DmaSource = src;
    step();
    bus.DmaStart = 0;
  endtask
  initial begin
    bus.Mode = 2'd0;
    bus.VramBank = 0;
    bus.CpuAccess = 0;
    bus.CpuWrite = 0;
    bus.CpuAddress = 16'h0000;
    bus.CpuWData = 8'h00;
    bus.PpuAccess = 0;
    bus.PpuAddress = 14'h0000;
    bus.PpuOamAddress = 8'h00;
    bus.DmaStart = 0;
    bus.DmaSource = 8'h00;
    for (int i = 0; i < 16384; i++) begin
      dev_vram[i] = 8'($urandom);
      vram_m[i] = dev_vram[i];
    end
    for (int i = 0; i < 160; i++) oam_k[i] = 0;
    model_reset();
    ClkEn = 1;
    @(negedge Clk);
    #1;
    chk("rst_ready", 16'(bus.CpuDataReady), 16'h0000);
    chk("rst_rdata", 16'(bus.CpuRData), 16'h00FF);
    chk("rst_ppu_oam", 16'(bus.PpuOamRData), 16'h00FF);
    chk("rst_dma_active", 16'(bus.DmaActive), 16'h0000);
    chk("rst_dma_access", 16'(bus.DmaAccess), 16'h0000);
    @(negedge Clk);
    nReset = 1;
    dma_kick(8'hC1);
    for (int k = 0; k < 320; k++) begin
      bus.CpuAccess = 1;
      bus.CpuAddress = 16'hFE00 + 16'(k % 160);
      step();
      chk("oam_blocked_dma", 16'(bus.CpuRData), 16'h00FF);
    end
    bus.CpuAccess = 0;
    chk("dma_done_c1", 16'(bus.DmaActive), 16'h0000);
    for (int i = 0; i < 160; i++) begin
      cpu_op(0, 16'hFE00 + 16'(i), 8'h00);
      chk("oam_c1", 16'(bus.CpuRData), 16'(8'(i) ^ 8'hA5));
    end
    bus.VramBank = 1;
    bus.CpuAccess = 1;
    bus.CpuAddress = 16'h8123;
    #1 chk("vaddr_cpu_bank1", 16'(bus.VramAddress), 16'h2123);
    cpu_op(1, 16'h8123, 8'h5A);
    cpu_op(0, 16'h8123, 8'h00);
    chk("vram_rdback", 16'(bus.CpuRData), 16'h005A);
    chk("vram_rdback_ready", 16'(bus.CpuDataReady), 16'h0001);
    bus.Mode = 2'd3;
    bus.VramBank = 0;
    cpu_op(0, 16'h8000, 8'h00);
    chk("vram_mode3_rd", 16'(bus.CpuRData), 16'h00FF);
    cpu_op(1, 16'h8001, 8'h77);
    bus.PpuAccess = 1;
    bus.PpuAddress = 14'h0040;
    #1 chk("vaddr_ppu", 16'(bus.VramAddress), 16'h0040);
    chk("ppu_no_write", 16'(bus.VramWrite), 16'h0000);
    step();
    bus.PpuAccess = 0;
    bus.Mode = 2'd0;
    cpu_op(0, 16'h8001, 8'h00);
    chk("vram_mode3_wr_dropped", 16'(bus.CpuRData), 16'(vram_m[1]));
    bus.Mode = 2'd2;
    cpu_op(1, 16'hFE00, 8'h11);
    bus.Mode = 2'd0;
    cpu_op(0, 16'hFE00, 8'h00);
    chk("oam_mode2_wr_dropped", 16'(bus.CpuRData), 16'h00A5);
    dma_kick(8'hC1);
    repeat (160) step();
    chk("dma_mid_addr", bus.DmaAddress, 16'hC150);
    dma_kick(8'hC2);
    chk("dma_restart_addr", bus.DmaAddress, 16'hC200);
    repeat (320) step();
    chk("dma_done_c2", 16'(bus.DmaActive), 16'h0000);
    for (int i = 0; i < 160; i++) begin
      cpu_op(0, 16'hFE00 + 16'(i), 8'h00);
      chk("oam_c2", 16'(bus.CpuRData), 16'(8'(i) ^ 8'hA5 ^ 8'hC2));
    end
    dma_kick(8'hC3);
    repeat (100) step();
    #2 nReset = 0;
    #1 chk("async_rst_dma_active", 16'(bus.DmaActive), 16'h0000);
    chk("async_rst_dma_access", 16'(bus.DmaAccess), 16'h0000);
    model_reset();
    @(negedge Clk);
    nReset = 1;
    for (int i = 0; i < 160; i++) begin
      cpu_op(0, 16'hFE00 + 16'(i), 8'h00);
      chk("oam_after_rst", 16'(bus.CpuRData), 16'(8'(i) ^ 8'hA5 ^ (i < 50 ? 8'hC3 : 8'hC2)));
    end
    repeat (4000) begin
      int sel;
      ClkEn = $urandom_range(0, 3) != 0;
      bus.Mode = 2'($urandom_range(0, 3));
      bus.VramBank = 1'($urandom);
      bus.CpuAccess = 1'($urandom);
      bus.CpuWrite = 1'($urandom);
      sel = $urandom_range(0, 2);
      bus.CpuAddress = sel == 0 ? 16'h8000 | 16'($urandom_range(0, 255)) :
                       sel == 1 ? 16'hFE00 + 16'($urandom_range(0, 175)) : 16'($urandom);
      bus.CpuWData = 8'($urandom);
      bus.PpuAccess = 1'($urandom);
      bus.PpuAddress = 14'($urandom);
      bus.PpuOamAddress = 8'($urandom_range(0, 159));
      bus.DmaStart = $urandom_range(0, 399) == 0;
      bus.DmaSource = 8'($urandom);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
